// File: rtl/mult_seq_controller.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier sequenced over a single shared 2x2 multiplier.
// Optional feature: define MULT_SEQ_ZERO_SKIP_EN to finish zero-operand requests on the start edge.

module multiplier (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] y
);
  assign y = {2'b00, a} * {2'b00, b};
endmodule

module mult_seq_controller #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int ND = WIDTH / 2;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(ND - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_l, b_l;
  logic [PW-1:0]   acc, pp_sh, sum;
  logic [IW-1:0]   i, j;
  logic [IW:0]     dsum;
  logic [1:0]      a_dig, b_dig;
  logic [3:0]      pp;
  logic            accept, zero_op, last;

  // digit i of a and digit j of b feed the one shared 2x2 multiplier
  assign a_dig = 2'(a_l >> {i, 1'b0});
  assign b_dig = 2'(b_l >> {j, 1'b0});

  multiplier u_mult (
    .a (a_dig),
    .b (b_dig),
    .y (pp)
  );

  assign dsum   = {1'b0, i} + {1'b0, j};
  assign pp_sh  = PW'(pp) << {dsum, 1'b0};
  assign sum    = acc + pp_sh;
  assign last   = (i == LAST) && (j == LAST);
  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef MULT_SEQ_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_op ? DONE : RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = zero_op ? DONE : RUN;
               else       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flops tracking the decoded next state, so they equal (state==RUN/DONE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_l     <= '0;
      b_l     <= '0;
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      product <= '0;
    end else if (accept) begin
      a_l <= a;
      b_l <= b;
      acc <= '0;
      i   <= '0;
      j   <= '0;
      if (zero_op) product <= '0;
    end else if (state == RUN) begin
      acc <= sum;
      if (j == LAST) begin
        j <= '0;
        i <= i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
      // product is only ever written with the complete sum
      if (last) product <= sum;
    end
  end
endmodule

// File: tb/tb_mult_seq_controller.sv
// Bench for mult_seq_controller: cycle-level reference model plus directed and random stimulus.
module tb_mult_seq_controller;
  localparam int WIDTH = 8;
  localparam int ND    = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done;
  logic [PW-1:0]    product;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  mult_seq_controller #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an accepted request finishes ND*ND edges later with the plain product a*b.
  logic          m_busy, m_done;
  logic [PW-1:0] m_prod, m_pend;
  int            m_cnt;
  logic          m_zero;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  assign m_zero = (a == 0) || (b == 0);
`else
  assign m_zero = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_pend <= '0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_pend;
      end
    end else if (start) begin
      m_pend <= PW'(a) * PW'(b);
      if (m_zero) begin
        m_done <= 1'b1;
        m_prod <= '0;
      end else begin
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_cnt  <= ND * ND;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("product", 32'(product), 32'(m_prod));
    if (done) n_done++;
  end

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [PW-1:0] exp_p, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_product"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int lat;
    int d0;
    repeat (2) @(negedge clk);
    check("reset_product", 32'(product), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // full-scale operands
    run_op(8'hFF, 8'hFF, 16'hFE01, 17, "ff_x_ff");
    run_op(8'h0D, 8'h0B, 16'h008F, 17, "d_x_b");
    repeat (3) @(negedge clk);
    check("hold_product", 32'(product), 32'h008F);

    // restart attempt in the middle of RUN must be ignored
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; a = 8'h0D; b = 8'h0B;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    repeat (5) @(negedge clk);
    check("ignored_start_dones", 32'(n_done - d0), 32'd1);
    check("ignored_start_product", 32'(product), 32'h008F);

    // asynchronous abort mid-RUN
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_product", 32'(product), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    run_op(8'h21, 8'h13, 16'h0273, 17, "after_abort");

    // start held through DONE: re-enter RUN with no idle cycle
    @(negedge clk);
    start = 1'b1; a = 8'h03; b = 8'h05;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_product", 32'(product), 32'h000F);
    @(negedge clk);
    check("b2b_no_gap_busy", 32'(busy), 32'h1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_product", 32'(product), 32'h000F);

    // zero operand
`ifdef MULT_SEQ_ZERO_SKIP_EN
    run_op(8'h00, 8'h9C, 16'h0000, 1, "zero_op");
`else
    run_op(8'h00, 8'h9C, 16'h0000, 17, "zero_op");
`endif

    // random traffic, including zero operands and rare resets
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom);
      b = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);
    run_op(8'hC3, 8'h7E, 16'h5FFA, 17, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
